// File: rtl/maze_grid_nav.sv
// Grid-based player position engine with a goal/win/restart FSM, blocked-move pulse and
// saturating move counter. Define MAZE_TIMEOUT_EN to add a per-game tick timeout.
module maze_grid_nav #(
  parameter int ROWS          = 4,
  parameter int COLS          = 4,
  parameter int START_IDX     = 0,
  parameter int GOAL_IDX      = 15,
  parameter int CNT_W         = 8,
  parameter int TIMEOUT_TICKS = 200
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          tick,
  input  logic [2:0]                    move,
  input  logic                          confirm,
  input  logic [ROWS*COLS-1:0]          wall_e,
  input  logic [ROWS*COLS-1:0]          wall_s,
  output logic [$clog2(ROWS*COLS)-1:0]  cell_idx,
  output logic [$clog2(ROWS)-1:0]       row,
  output logic [$clog2(COLS)-1:0]       col,
  output logic                          at_goal,
  output logic                          win_show,
  output logic                          bump,
  output logic [CNT_W-1:0]              move_count,
  output logic                          timed_out
);

  localparam int IDX_W = $clog2(ROWS*COLS);
  localparam int RW    = $clog2(ROWS);
  localparam int CW    = $clog2(COLS);
  localparam logic [RW-1:0]    START_ROW = RW'(START_IDX / COLS);
  localparam logic [CW-1:0]    START_COL = CW'(START_IDX % COLS);
  localparam logic [IDX_W-1:0] GOAL_I    = IDX_W'(GOAL_IDX);

  localparam logic [2:0] MV_LEFT  = 3'b001;
  localparam logic [2:0] MV_RIGHT = 3'b010;
  localparam logic [2:0] MV_DOWN  = 3'b011;
  localparam logic [2:0] MV_UP    = 3'b100;

  if (ROWS < 2 || ROWS > 16 || COLS < 2 || COLS > 16 || TIMEOUT_TICKS < 1) begin : g_param_check
    $error("maze_grid_nav: parameter out of range");
  end

  typedef enum logic [1:0] {S_PLAY, S_GOAL, S_WIN} state_e;

  state_e           state_q, state_d;
  logic [RW-1:0]    row_q, row_d, tgt_row;
  logic [CW-1:0]    col_q, col_d, tgt_col;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bump_q, bump_d;
  logic [IDX_W-1:0] cur_idx, idx_left, idx_up, tgt_idx;
  logic             is_move, legal;

`ifdef MAZE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          timed_out_q, timed_out_d;
`endif

  assign cur_idx  = IDX_W'(row_q) * IDX_W'(COLS) + IDX_W'(col_q);
  assign idx_left = cur_idx - IDX_W'(1);
  assign idx_up   = cur_idx - IDX_W'(COLS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_PLAY;
      row_q   <= START_ROW;
      col_q   <= START_COL;
      cnt_q   <= '0;
      bump_q  <= 1'b0;
`ifdef MAZE_TIMEOUT_EN
      tcnt_q      <= '0;
      timed_out_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      cnt_q   <= cnt_d;
      bump_q  <= bump_d;
`ifdef MAZE_TIMEOUT_EN
      tcnt_q      <= tcnt_d;
      timed_out_q <= timed_out_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    cnt_d   = cnt_q;
    bump_d  = 1'b0;
    tgt_row = row_q;
    tgt_col = col_q;
    is_move = 1'b0;
    legal   = 1'b0;
`ifdef MAZE_TIMEOUT_EN
    tcnt_d      = tcnt_q;
    timed_out_d = timed_out_q;
`endif
    // Grid edges count as walls, so the last column/row wall bits are never consulted
    case (move)
      MV_LEFT: begin
        is_move = 1'b1;
        legal   = (col_q != '0) && !wall_e[idx_left];
        tgt_col = col_q - CW'(1);
      end
      MV_RIGHT: begin
        is_move = 1'b1;
        legal   = (col_q < CW'(COLS-1)) && !wall_e[cur_idx];
        tgt_col = col_q + CW'(1);
      end
      MV_DOWN: begin
        is_move = 1'b1;
        legal   = (row_q < RW'(ROWS-1)) && !wall_s[cur_idx];
        tgt_row = row_q + RW'(1);
      end
      MV_UP: begin
        is_move = 1'b1;
        legal   = (row_q != '0) && !wall_s[idx_up];
        tgt_row = row_q - RW'(1);
      end
      default: ;
    endcase
    tgt_idx = IDX_W'(tgt_row) * IDX_W'(COLS) + IDX_W'(tgt_col);

    if (tick) begin
      case (state_q)
        S_PLAY: begin
          if (legal) begin
            row_d = tgt_row;
            col_d = tgt_col;
            if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
            if (tgt_idx == GOAL_I) state_d = S_GOAL;
          end else if (is_move) begin
            bump_d = 1'b1;
          end
        end
        S_GOAL: if (confirm) state_d = S_WIN;
        S_WIN: begin
          if (confirm) begin
            state_d = S_PLAY;
            row_d   = START_ROW;
            col_d   = START_COL;
            cnt_d   = '0;
          end
        end
        default: state_d = S_PLAY;
      endcase
`ifdef MAZE_TIMEOUT_EN
      // Reaching the goal on the firing tick takes precedence over the timeout
      if (state_q == S_PLAY && state_d == S_PLAY) begin
        if (tcnt_q == TW'(TIMEOUT_TICKS)) begin
          tcnt_d      = '0;
          timed_out_d = 1'b1;
          row_d       = START_ROW;
          col_d       = START_COL;
          cnt_d       = '0;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
          if (legal) timed_out_d = 1'b0;
        end
      end else if (state_q == S_WIN && state_d == S_PLAY) begin
        tcnt_d = '0;
      end
`endif
    end
  end

  always_comb begin
    cell_idx   = cur_idx;
    row        = row_q;
    col        = col_q;
    at_goal    = (state_q == S_GOAL);
    win_show   = (state_q == S_WIN);
    bump       = bump_q;
    move_count = cnt_q;
`ifdef MAZE_TIMEOUT_EN
    timed_out  = timed_out_q;
`else
    timed_out  = 1'b0;
`endif
  end

endmodule

// File: tb/tb_maze_grid_nav.sv
// Directed scoreboard bench for maze_grid_nav on a 4x4 grid (start 0, goal 15).
module tb_maze_grid_nav;
  localparam int COLS = 4;
  localparam logic [2:0] STAY  = 3'b000;
  localparam logic [2:0] LEFT  = 3'b001;
  localparam logic [2:0] RIGHT = 3'b010;
  localparam logic [2:0] DOWN  = 3'b011;
  localparam logic [2:0] UP    = 3'b100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick = 1'b0;
  logic [2:0]  move = 3'b000;
  logic        confirm = 1'b0;
  logic [15:0] wall_e = '0;
  logic [15:0] wall_s = '0;
  logic [3:0]  cell_idx;
  logic [1:0]  row, col;
  logic        at_goal, win_show, bump, timed_out;
  logic [7:0]  move_count;
  bit          clk_run = 1'b1;

  typedef struct {
    int idx;
    int cnt;
    bit bmp;
    bit goal;
    bit win;
    bit tout;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  maze_grid_nav #(
    .ROWS(4), .COLS(4), .START_IDX(0), .GOAL_IDX(15), .CNT_W(8), .TIMEOUT_TICKS(5)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .move(move), .confirm(confirm),
    .wall_e(wall_e), .wall_s(wall_s), .cell_idx(cell_idx), .row(row), .col(col),
    .at_goal(at_goal), .win_show(win_show), .bump(bump), .move_count(move_count),
    .timed_out(timed_out)
  );

  always #5 if (clk_run) clk = ~clk;

  task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_output(input string step);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("[TB] FAIL %s scoreboard_empty observed=0 expected=1", step);
      return;
    end
    e = sb.pop_front();
    compare({step, ".idx"},  32'(cell_idx),   e.idx);
    compare({step, ".row"},  32'(row),        e.idx / COLS);
    compare({step, ".col"},  32'(col),        e.idx % COLS);
    compare({step, ".cnt"},  32'(move_count), e.cnt);
    compare({step, ".bump"}, 32'(bump),       32'(e.bmp));
    compare({step, ".goal"}, 32'(at_goal),    32'(e.goal));
    compare({step, ".win"},  32'(win_show),   32'(e.win));
    compare({step, ".tout"}, 32'(timed_out),  32'(e.tout));
  endtask

  task automatic apply_stimulus(input logic tk, input logic [2:0] mv, input logic cf,
                                input int e_idx, input int e_cnt, input bit e_bmp,
                                input bit e_goal, input bit e_win, input bit e_to,
                                input string step);
    exp_t e;
    @(negedge clk);
    tick = tk;
    move = mv;
    confirm = cf;
    e = '{e_idx, e_cnt, e_bmp, e_goal, e_win, e_to};
    sb.push_back(e);
    @(posedge clk);
    #1;
    tick = 1'b0;
    confirm = 1'b0;
    check_output(step);
  endtask

  task automatic play(input logic [2:0] mv, input int e_idx, input int e_cnt,
                      input bit e_bmp, input string step);
    apply_stimulus(1'b1, mv, 1'b0, e_idx, e_cnt, e_bmp, 1'b0, 1'b0, 1'b0, step);
  endtask

  task automatic do_reset(input string step);
    exp_t e;
    @(negedge clk);
    rst_n = 1'b0;
    e = '{0, 0, 1'b0, 1'b0, 1'b0, 1'b0};
    sb.push_back(e);
    #1;
    check_output(step);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    exp_t e;
    #12;
    e = '{0, 0, 1'b0, 1'b0, 1'b0, 1'b0};
    sb.push_back(e);
    check_output("reset");
    @(negedge clk);
    rst_n = 1'b1;

`ifdef MAZE_TIMEOUT_EN
    play(RIGHT, 1, 1, 1'b0, "to_r");
    for (int i = 0; i < 4; i++) play(STAY, 1, 1, 1'b0, "to_stay");
    apply_stimulus(1'b1, STAY, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, "to_fire");
    play(RIGHT, 1, 1, 1'b0, "to_clear");
`else
    play(RIGHT, 1, 1, 1'b0, "r1");
    play(RIGHT, 2, 2, 1'b0, "r2");
    play(RIGHT, 3, 3, 1'b0, "r3");
    play(RIGHT, 3, 3, 1'b1, "r_edge");
    apply_stimulus(1'b0, LEFT, 1'b0, 3, 3, 1'b0, 1'b0, 1'b0, 1'b0, "no_tick");
    wall_e[2] = 1'b1;
    play(LEFT, 3, 3, 1'b1, "l_wall");
    wall_e[2] = 1'b0;
    play(LEFT, 2, 4, 1'b0, "l_open");

    do_reset("reset2");
    wall_s[0] = 1'b1;
    play(DOWN, 0, 0, 1'b1, "d_wall");
    play(LEFT, 0, 0, 1'b1, "l_edge");
    play(UP, 0, 0, 1'b1, "u_edge");
    wall_s[0] = 1'b0;
    play(DOWN, 4, 1, 1'b0, "d_open");
    wall_s[0] = 1'b1;
    play(UP, 4, 1, 1'b1, "u_wall");
    wall_s[0] = 1'b0;
    play(UP, 0, 2, 1'b0, "u_open");
    play(3'b101, 0, 2, 1'b0, "code101");
    play(STAY, 0, 2, 1'b0, "stay");
    play(3'b111, 0, 2, 1'b0, "code111");

    play(RIGHT, 1, 3, 1'b0, "w_r1");
    play(RIGHT, 2, 4, 1'b0, "w_r2");
    play(RIGHT, 3, 5, 1'b0, "w_r3");
    wall_e[3] = 1'b1;
    play(DOWN, 7, 6, 1'b0, "w_d1");
    play(DOWN, 11, 7, 1'b0, "w_d2");
    apply_stimulus(1'b1, DOWN, 1'b0, 15, 8, 1'b0, 1'b1, 1'b0, 1'b0, "w_goal");
    wall_e[3] = 1'b0;
    apply_stimulus(1'b1, LEFT, 1'b0, 15, 8, 1'b0, 1'b1, 1'b0, 1'b0, "goal_move");
    apply_stimulus(1'b0, STAY, 1'b1, 15, 8, 1'b0, 1'b1, 1'b0, 1'b0, "goal_notick");
    apply_stimulus(1'b1, STAY, 1'b1, 15, 8, 1'b0, 1'b0, 1'b1, 1'b0, "win");
    apply_stimulus(1'b1, STAY, 1'b0, 15, 8, 1'b0, 1'b0, 1'b1, 1'b0, "win_hold");
    apply_stimulus(1'b1, RIGHT, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, "restart");

    for (int i = 0; i < 260; i++) begin
      play((i % 2 == 0) ? RIGHT : LEFT, (i % 2 == 0) ? 1 : 0,
           (i + 1 > 255) ? 255 : i + 1, 1'b0, "sat");
    end

    play(RIGHT, 1, 255, 1'b0, "h_r1");
    play(RIGHT, 2, 255, 1'b0, "h_r2");
    play(RIGHT, 3, 255, 1'b0, "h_r3");
    play(DOWN, 7, 255, 1'b0, "h_d1");
    play(DOWN, 11, 255, 1'b0, "h_d2");
    apply_stimulus(1'b1, DOWN, 1'b0, 15, 255, 1'b0, 1'b1, 1'b0, 1'b0, "h_goal");
    apply_stimulus(1'b1, STAY, 1'b1, 15, 255, 1'b0, 1'b0, 1'b1, 1'b0, "h_win");

    clk_run = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    e = '{0, 0, 1'b0, 1'b0, 1'b0, 1'b0};
    sb.push_back(e);
    check_output("async_reset");
    #5;
    clk_run = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    play(RIGHT, 1, 1, 1'b0, "post_reset");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
